// File: rtl/gba_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : gba_bus_arbiter
// Brief   : Arbitrates the system memory bus between the CPU (default owner)
//           and NUM_DMA fixed-priority DMA channels (channel 0 highest).
// Revision: 1.0 - initial release
// ============================================================================
module gba_bus_arbiter #(
    parameter int NUM_DMA     = 4,
    parameter int HANDOFF_CYC = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    input  logic [1:0]             cpu_size,
    input  logic                   cpu_write,
    output logic                   cpu_pause,
    output logic                   dma_active,
    input  logic [NUM_DMA-1:0]     dma_req,
    output logic [NUM_DMA-1:0]     dma_grant,
    input  logic [32*NUM_DMA-1:0]  dma_addr,
    input  logic [32*NUM_DMA-1:0]  dma_wdata,
    input  logic [2*NUM_DMA-1:0]   dma_size,
    input  logic [NUM_DMA-1:0]     dma_write,
    output logic [31:0]            bus_addr,
    output logic [31:0]            bus_wdata,
    output logic [1:0]             bus_size,
    output logic                   bus_write,
    input  logic                   bus_pause,
    output logic [2:0]             owner
);

    typedef enum logic [1:0] {
        S_CPU_OWN = 2'd0,
        S_HANDOFF = 2'd1,
        S_DMA_OWN = 2'd2,
        S_RETURN  = 2'd3
    } state_t;

    localparam logic [1:0] c_CNT_LAST = 2'(HANDOFF_CYC - 1);

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_target, w_target_nxt;
    logic [1:0]           r_cnt, w_cnt_nxt;
    logic [NUM_DMA-1:0]   r_grant, w_grant_nxt;
    logic                 r_active;
    logic [2:0]           r_owner, w_owner_nxt;
    logic                 w_any_req, w_tgt_req, w_boundary;
    logic [1:0]           w_winner;

    // Lowest-index requester wins; also look up whether the target still requests.
    always_comb begin
        w_any_req  = |dma_req;
        w_boundary = ~bus_pause;
        w_winner   = 2'd0;
        w_tgt_req  = 1'b0;
        for (int i = NUM_DMA - 1; i >= 0; i--) begin
            if (dma_req[i]) w_winner = 2'(i);
        end
        for (int i = 0; i < NUM_DMA; i++) begin
            if (r_target == 2'(i)) w_tgt_req = dma_req[i];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_CPU_OWN: begin
                if (w_any_req && w_boundary) begin
                    w_state_nxt  = S_HANDOFF;
                    w_target_nxt = w_winner;
                    w_cnt_nxt    = 2'd0;
                end
            end
            S_HANDOFF: begin
                if (!w_tgt_req) begin
                    w_cnt_nxt = 2'd0;
                    if (w_any_req) w_target_nxt = w_winner;
                    else           w_state_nxt  = S_RETURN;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_DMA_OWN;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            S_DMA_OWN: begin
                // A different winner means either preemption or the owner finished.
                if (w_boundary) begin
                    w_cnt_nxt = 2'd0;
                    if (!w_any_req) begin
                        w_state_nxt = S_RETURN;
                    end else if (w_winner != r_target) begin
                        w_state_nxt  = S_HANDOFF;
                        w_target_nxt = w_winner;
                    end
                end
            end
            S_RETURN: begin
                if (w_any_req) begin
                    w_state_nxt  = S_HANDOFF;
                    w_target_nxt = w_winner;
                    w_cnt_nxt    = 2'd0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_CPU_OWN;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            default: w_state_nxt = S_CPU_OWN;
        endcase

        for (int i = 0; i < NUM_DMA; i++) begin
            w_grant_nxt[i] = (w_state_nxt == S_DMA_OWN) && (w_target_nxt == 2'(i));
        end
        w_owner_nxt = (w_state_nxt == S_CPU_OWN) ? 3'd0 : ({1'b0, w_target_nxt} + 3'd1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_CPU_OWN;
            r_target <= 2'd0;
            r_cnt    <= 2'd0;
            r_grant  <= '0;
            r_active <= 1'b0;
            r_owner  <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_cnt    <= w_cnt_nxt;
            r_grant  <= w_grant_nxt;
            r_active <= (w_state_nxt != S_CPU_OWN);
            r_owner  <= w_owner_nxt;
        end
    end

    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_size  = cpu_size;
        bus_write = cpu_write;
        if (r_state == S_DMA_OWN) begin
            for (int i = 0; i < NUM_DMA; i++) begin
                if (r_target == 2'(i)) begin
                    bus_addr  = dma_addr[32*i +: 32];
                    bus_wdata = dma_wdata[32*i +: 32];
                    bus_size  = dma_size[2*i +: 2];
                    bus_write = dma_write[i];
                end
            end
        end
        // Dead cycles between owners never carry a write.
        if (r_state == S_HANDOFF || r_state == S_RETURN) bus_write = 1'b0;
        cpu_pause = bus_pause | (r_state != S_CPU_OWN);
    end

    assign dma_grant  = r_grant;
    assign dma_active = r_active;
    assign owner      = r_owner;

endmodule
`default_nettype wire
